// File: rtl/bch_dec_pkg.sv
// Shared constants and helpers for the 41/31 SEC-DED decoder.
// The data-column table is built by enumerating weight-3 values in ascending order.
package bch_dec_pkg;

  localparam int N = 41;
  localparam int K = 31;
  localparam int R = 10;

  typedef logic [R-1:0]         syn_t;
  typedef logic [K-1:0][R-1:0]  col_tab_t;

  function automatic logic [3:0] popcount10(input syn_t v);
    logic [3:0] cnt;
    cnt = '0;
    for (int b = 0; b < R; b++) begin
      cnt = cnt + {3'b000, v[b]};
    end
    return cnt;
  endfunction

  function automatic col_tab_t gen_w();
    col_tab_t tab;
    int       idx;
    tab = '0;
    idx = 0;
    for (int v = 0; v < (1 << R); v++) begin
      if (popcount10(syn_t'(v)) == 4'd3 && idx < K) begin
        tab[idx] = syn_t'(v);
        idx++;
      end
    end
    return tab;
  endfunction

  localparam col_tab_t W = gen_w();

endpackage

// File: rtl/bch_syndrome.sv
// Syndrome XOR tree: each syndrome bit folds its check bit with the data bits
// whose column has that row set.
module bch_syndrome
  import bch_dec_pkg::*;
(
  input  logic [N-1:0] i_cw,
  output logic [R-1:0] o_syn
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < R; gi++) begin : g_row
      logic [K-1:0] w_sel;
      for (gj = 0; gj < K; gj++) begin : g_col
        assign w_sel[gj] = W[gj][gi] & i_cw[R+gj];
      end
      assign o_syn[gi] = i_cw[gi] ^ (^w_sel);
    end
  endgenerate

endmodule

// File: rtl/bch_dec_top.sv
// Combinational SEC-DED decoder: syndrome, one-hot data correction mask and
// single/double error classification. clk and rst_n exist only for port uniformity.
module bch_dec_top
  import bch_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] IN,
  output logic [K-1:0] OUT,
  output logic [R-1:0] SYN,
  output logic         ERR,
  output logic         SGL,
  output logic         DBL
);

  logic [R-1:0] w_syn;
  logic [K-1:0] w_hit;
  logic [3:0]   w_wt;
  logic         w_nz;
  logic         w_odd;
  logic         w_wt1;
  logic         w_data_sgl;
  logic         w_unused;

  assign w_unused = clk ^ rst_n;

  bch_syndrome u_syn (
    .i_cw  (IN),
    .o_syn (w_syn)
  );

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_cmp
      assign w_hit[gi] = (w_syn == W[gi]);
    end
  endgenerate

  assign w_wt       = popcount10(w_syn);
  assign w_nz       = |w_syn;
  assign w_odd      = w_wt[0];
  assign w_wt1      = (w_wt == 4'd1);
  assign w_data_sgl = |w_hit;

  // Even-weight syndromes can never match a column, so parity gates correction.
  assign SGL = w_odd & (w_data_sgl | w_wt1);
  assign DBL = w_nz & ~SGL;
  assign ERR = w_nz;
  assign SYN = w_syn;
  assign OUT = IN[N-1:R] ^ (w_hit & {K{w_odd}});

endmodule

// File: tb/tb_bch_dec_top.sv
// Directed and randomized checks of the SEC-DED decoder against hand values
// and an error-injection model.
module tb_bch_dec_top;

  logic        clk;
  logic        rst_n;
  logic [40:0] IN;
  logic [30:0] OUT;
  logic [9:0]  SYN;
  logic        ERR, SGL, DBL;

  int total = 0;
  int bad   = 0;
  logic [9:0] wtab [31];

  bch_dec_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .IN    (IN),
    .OUT   (OUT),
    .SYN   (SYN),
    .ERR   (ERR),
    .SGL   (SGL),
    .DBL   (DBL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] col_of(input int p);
    if (p < 10) return 10'(1 << p);
    return wtab[p-10];
  endfunction

  task automatic test_reset();
    logic [43:0] obs, exp;
    rst_n = 1'b0;
    IN = '0;
    #2;
    obs = {OUT, SYN, ERR, SGL, DBL};
    exp = '0;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_zero got=%h want=%h", obs, exp);
    end
    IN = 41'h1 << 10;
    #2;
    obs = {OUT, SYN, ERR, SGL, DBL};
    exp = {31'h0, 10'h007, 1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_tracks got=%h want=%h", obs, exp);
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_valid();
    logic [43:0] obs, exp;
    IN = (41'h1 << 10) | 41'h007;
    #2;
    obs = {OUT, SYN, ERR, SGL, DBL};
    exp = {31'h1, 10'h000, 3'b000};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL valid_cw got=%h want=%h", obs, exp);
    end
    $display("valid IN=%h SYN=%h OUT=%h", IN, SYN, OUT);
  endtask

  task automatic test_single_data();
    logic [43:0] obs, exp;
    IN = 41'h1 << 10;
    #2;
    obs = {OUT, SYN, ERR, SGL, DBL};
    exp = {31'h0, 10'h007, 3'b110};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL single_d0 got=%h want=%h", obs, exp);
    end
    IN = 41'h1 << 14;
    #2;
    total++;
    if (SYN !== 10'h013) begin
      bad++;
      $display("FAIL single_d4_syn got=%h want=%h", SYN, 10'h013);
    end
    for (int j = 0; j < 31; j++) begin
      IN = 41'h1 << (10 + j);
      #2;
      obs = {OUT, SYN, ERR, SGL, DBL};
      exp = {31'h0, wtab[j], 3'b110};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single_data j=%0d got=%h want=%h", j, obs, exp);
      end
      $display("single data j=%0d SYN=%h OUT=%h", j, SYN, OUT);
    end
  endtask

  task automatic test_check_err();
    logic [43:0] obs, exp;
    for (int c = 0; c < 10; c++) begin
      IN = 41'h1 << c;
      #2;
      obs = {OUT, SYN, ERR, SGL, DBL};
      exp = {31'h0, 10'(1 << c), 3'b110};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL check_err c=%0d got=%h want=%h", c, obs, exp);
      end
      $display("check err c=%0d SYN=%h", c, SYN);
    end
  endtask

  task automatic test_double();
    logic [43:0] obs, exp;
    IN = (41'h1 << 10) | (41'h1 << 11);
    #2;
    obs = {OUT, SYN, ERR, SGL, DBL};
    exp = {31'h3, 10'h00C, 3'b101};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL double got=%h want=%h", obs, exp);
    end
    $display("double SYN=%h OUT=%h", SYN, OUT);
  endtask

  task automatic test_odd_unmatched();
    logic [43:0] obs, exp;
    IN = 41'h01F;
    #2;
    obs = {OUT, SYN, ERR, SGL, DBL};
    exp = {31'h0, 10'h01F, 3'b101};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL odd_unmatched got=%h want=%h", obs, exp);
    end
    $display("odd unmatched SYN=%h DBL=%b", SYN, DBL);
  endtask

  task automatic test_random();
    logic [43:0] obs, exp;
    logic [30:0] data;
    logic [9:0]  chk, esyn;
    logic [40:0] cw;
    int nerr, p0, p1;
    for (int t = 0; t < 60; t++) begin
      data = 31'($urandom);
      chk  = '0;
      for (int j = 0; j < 31; j++) if (data[j]) chk ^= wtab[j];
      cw   = {data, chk};
      nerr = t % 3;
      p0   = $urandom_range(40, 0);
      p1   = (p0 + 1 + $urandom_range(39, 0)) % 41;
      if (nerr == 0) begin
        exp = {data, 10'h0, 3'b000};
      end else if (nerr == 1) begin
        cw[p0] = ~cw[p0];
        exp = {data, col_of(p0), 3'b110};
      end else begin
        cw[p0] = ~cw[p0];
        cw[p1] = ~cw[p1];
        esyn = col_of(p0) ^ col_of(p1);
        exp = {cw[40:10], esyn, 3'b101};
      end
      IN = cw;
      #2;
      obs = {OUT, SYN, ERR, SGL, DBL};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL random t=%0d nerr=%0d IN=%h got=%h want=%h", t, nerr, cw, obs, exp);
      end
      $display("random t=%0d nerr=%0d IN=%h SYN=%h", t, nerr, cw, SYN);
    end
  endtask

  task automatic test_clock_static();
    logic [43:0] obs, exp;
    IN = (41'h1 << 40) | 41'h200;
    #17;
    obs = {OUT, SYN, ERR, SGL, DBL};
    exp = {31'h4000_0000, 10'h200 ^ wtab[30], 3'b101};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL clock_hold got=%h want=%h", obs, exp);
    end
    $display("clock hold SYN=%h", SYN);
  endtask

  initial begin
    begin
      int idx;
      idx = 0;
      for (int v = 0; v < 1024 && idx < 31; v++) begin
        if ($countones(v[9:0]) == 3) begin
          wtab[idx] = v[9:0];
          idx++;
        end
      end
    end
    rst_n = 1'b1;
    IN = '0;
    test_reset();
    test_valid();
    test_single_data();
    test_check_err();
    test_double();
    test_odd_unmatched();
    test_clock_static();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
